// File: rtl/shape_color_classifier.sv
// Streaming single-object classifier: dominant colour plus triangle/circle/square
// figure from per-row object widths, one pixel per valid beat, no frame buffer.
//
// state | meaning
// IDLE  | waiting for start; results hold
// ARM   | waiting for the start-of-frame pixel
// ACCUM | accumulating sums, row widths and row statistics
// EVAL  | results presented with done, then back to IDLE
module shape_color_classifier #(
  parameter int W       = 160,
  parameter int H       = 120,
  parameter int CW      = 4,
  parameter int SAT_THR = 4,
  parameter int MIN_W   = 3,
  localparam int CNT_W  = $clog2(W*H+1),
  localparam int ACC_W  = CW + CNT_W,
  localparam int XW     = $clog2(W),
  localparam int YW     = $clog2(H),
  localparam int RW     = $clog2(W+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [3*CW-1:0]  pix_data,
  output logic             busy,
  output logic             done,
  output logic [1:0]       color,
  output logic [1:0]       figure,
  output logic [CNT_W-1:0] obj_pixels
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_EVAL  = 2'd3;

  // One bit wider than the nominal YW+3 so that 8*H cannot wrap when H is a power of two.
  localparam int FW = YW + 4;

  logic [1:0]       state;
  logic [XW-1:0]    x_q, b_x;
  logic [YW-1:0]    y_q, b_y;
  logic [RW-1:0]    width_q, prev_q, b_width, b_prev, row_w;
  logic [YW:0]      valid_q, grow_q, b_valid, b_grow;
  logic [CNT_W-1:0] cnt_q, b_cnt;
  logic [ACC_W-1:0] sum_r_q, sum_g_q, sum_b_q, b_sum_r, b_sum_g, b_sum_b;
  logic [1:0]       color_q, figure_q, color_calc, figure_calc;
  logic [CNT_W-1:0] obj_q;

  logic [CW-1:0] ch_r, ch_g, ch_b, ch_max, ch_min;
  logic          is_obj, row_end, last_pix, row_ok, row_grow, take;
  logic [FW-1:0] g4, g8, v3, v5;

  always_comb begin
    ch_r = pix_data[3*CW-1 -: CW];
    ch_g = pix_data[2*CW-1 -: CW];
    ch_b = pix_data[CW-1:0];
    ch_max = ch_r;
    ch_min = ch_r;
    if (ch_g > ch_max) ch_max = ch_g;
    if (ch_b > ch_max) ch_max = ch_b;
    if (ch_g < ch_min) ch_min = ch_g;
    if (ch_b < ch_min) ch_min = ch_b;
    is_obj = (ch_max - ch_min) >= CW'(SAT_THR);

    // A sof pixel restarts the frame: it is processed against cleared counters.
    b_x     = pix_sof ? '0 : x_q;
    b_y     = pix_sof ? '0 : y_q;
    b_width = pix_sof ? '0 : width_q;
    b_prev  = pix_sof ? '0 : prev_q;
    b_valid = pix_sof ? '0 : valid_q;
    b_grow  = pix_sof ? '0 : grow_q;
    b_cnt   = pix_sof ? '0 : cnt_q;
    b_sum_r = pix_sof ? '0 : sum_r_q;
    b_sum_g = pix_sof ? '0 : sum_g_q;
    b_sum_b = pix_sof ? '0 : sum_b_q;

    row_w    = b_width + RW'(is_obj);
    row_end  = (b_x == XW'(W-1));
    last_pix = row_end && (b_y == YW'(H-1));
    row_ok   = row_w > RW'(MIN_W);
    row_grow = row_ok && (row_w > b_prev);
    take     = pix_valid && ((state == S_ARM && pix_sof) || state == S_ACCUM);
  end

  always_comb begin
    color_calc = 2'd0;
    if (sum_r_q > sum_g_q && sum_r_q > sum_b_q)      color_calc = 2'd1;
    else if (sum_g_q > sum_r_q && sum_g_q > sum_b_q) color_calc = 2'd2;
    else if (sum_b_q > sum_r_q && sum_b_q > sum_g_q) color_calc = 2'd3;

    g4 = FW'(grow_q) << 2;
    g8 = FW'(grow_q) << 3;
    v3 = (FW'(valid_q) << 1) + FW'(valid_q);
    v5 = (FW'(valid_q) << 2) + FW'(valid_q);
    figure_calc = 2'd3;
    if (valid_q == '0)               figure_calc = 2'd0;
    else if (g4 >= v3)               figure_calc = 2'd1;
    else if (g8 > v3 && g8 < v5)     figure_calc = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      width_q  <= '0;
      prev_q   <= '0;
      valid_q  <= '0;
      grow_q   <= '0;
      cnt_q    <= '0;
      sum_r_q  <= '0;
      sum_g_q  <= '0;
      sum_b_q  <= '0;
      color_q  <= '0;
      figure_q <= '0;
      obj_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_ARM;
        S_EVAL: begin
          color_q  <= color_calc;
          figure_q <= figure_calc;
          obj_q    <= cnt_q;
          state    <= S_IDLE;
        end
        default: begin
          if (take) begin
            sum_r_q <= is_obj ? b_sum_r + ACC_W'(ch_r) : b_sum_r;
            sum_g_q <= is_obj ? b_sum_g + ACC_W'(ch_g) : b_sum_g;
            sum_b_q <= is_obj ? b_sum_b + ACC_W'(ch_b) : b_sum_b;
            cnt_q   <= b_cnt + CNT_W'(is_obj);
            if (row_end) begin
              x_q     <= '0;
              y_q     <= b_y + 1'b1;
              width_q <= '0;
              prev_q  <= row_w;
              valid_q <= b_valid + (YW+1)'(row_ok);
              grow_q  <= b_grow + (YW+1)'(row_grow);
            end else begin
              x_q     <= b_x + 1'b1;
              y_q     <= b_y;
              width_q <= row_w;
              prev_q  <= b_prev;
              valid_q <= b_valid;
              grow_q  <= b_grow;
            end
            state <= last_pix ? S_EVAL : S_ACCUM;
          end
        end
      endcase
    end
  end

  assign busy       = (state == S_ARM) || (state == S_ACCUM);
  assign done       = (state == S_EVAL);
  assign color      = done ? color_calc  : color_q;
  assign figure     = done ? figure_calc : figure_q;
  assign obj_pixels = done ? cnt_q       : obj_q;

endmodule

// File: tb/tb_shape_color_classifier.sv
// Bench for shape_color_classifier: frame table plus restart, reset-abort and
// start-during-done sequences, checked through a result scoreboard.
module tb_shape_color_classifier;

  localparam int W = 16;
  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [11:0] pix_data = 12'hFFF;
  logic        busy, done;
  logic [1:0]  color, figure;
  logic [7:0]  obj_pixels;

  shape_color_classifier #(.W(W), .H(H), .CW(4), .SAT_THR(4), .MIN_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_data(pix_data), .busy(busy), .done(done), .color(color), .figure(figure),
    .obj_pixels(obj_pixels)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]     obj;
    logic [7:0][3:0] w;
    int              exp_color;
    int              exp_fig;
    int              exp_pix;
  } vec_t;

  typedef struct {
    int color;
    int fig;
    int pix;
  } exp_t;

  vec_t vecs[4];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("color", int'(color), e.color);
        chk("figure", int'(figure), e.fig);
        chk("obj_pixels", int'(obj_pixels), e.pix);
        chk("busy_with_done", int'(busy), 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [11:0] d, input logic sof);
    pix_data  = d;
    pix_sof   = sof;
    pix_valid = 1'b1;
    cyc();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Object starts at column 2 of each row; npix truncates the frame.
  task automatic send_frame(input logic [11:0] obj, input logic [7:0][3:0] w, input int npix);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y*W + x < npix)
          beat((x >= 2 && x < 2 + int'(w[y])) ? obj : 12'hFFF, (x == 0 && y == 0));
      end
    end
  endtask

  task automatic push_exp(input int c, input int f, input int p);
    exp_t e;
    e.color = c;
    e.fig   = f;
    e.pix   = p;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    vecs[0] = '{obj: 12'hF00, w: {4'd11, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4},
                exp_color: 1, exp_fig: 1, exp_pix: 60};
    vecs[1] = '{obj: 12'h0F0, w: {4'd4, 4'd5, 4'd6, 4'd7, 4'd7, 4'd6, 4'd5, 4'd4},
                exp_color: 2, exp_fig: 2, exp_pix: 44};
    vecs[2] = '{obj: 12'h00F, w: {8{4'd6}}, exp_color: 3, exp_fig: 3, exp_pix: 48};
    vecs[3] = '{obj: 12'hFFF, w: {8{4'd0}}, exp_color: 0, exp_fig: 0, exp_pix: 0};

    cyc(); cyc();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_color", int'(color), 0);
    chk("reset_figure", int'(figure), 0);
    chk("reset_obj_pixels", int'(obj_pixels), 0);
    rst = 1'b1;
    cyc();

    // Pixels in IDLE are ignored; start arms the FSM.
    beat(12'hF00, 1'b1);
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 4; i++) begin
      do_start();
      chk("busy_after_start", int'(busy), 1);
      push_exp(vecs[i].exp_color, vecs[i].exp_fig, vecs[i].exp_pix);
      d0 = done_cnt;
      send_frame(vecs[i].obj, vecs[i].w, W*H);
      chk("latency_done", int'(done), 1);
      cyc();
      chk("done_one_pulse", int'(done), 0);
      chk("done_count", done_cnt - d0, 1);
      chk("hold_color", int'(color), vecs[i].exp_color);
      chk("hold_obj_pixels", int'(obj_pixels), vecs[i].exp_pix);
    end

    // Restart: partial frame then a fresh sof with the square frame; a mid-frame start is ignored.
    d0 = done_cnt;
    do_start();
    send_frame(vecs[1].obj, vecs[1].w, 40);
    do_start();
    chk("restart_busy", int'(busy), 1);
    push_exp(3, 3, 48);
    send_frame(vecs[2].obj, vecs[2].w, W*H);
    cyc();
    chk("restart_done_count", done_cnt - d0, 1);

    // Reset mid-frame aborts with no done, then a triangle frame completes.
    d0 = done_cnt;
    do_start();
    send_frame(vecs[0].obj, vecs[0].w, 40);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_color", int'(color), 0);
    cyc(); cyc();
    chk("abort_no_done", done_cnt - d0, 0);
    do_start();
    push_exp(1, 1, 60);
    send_frame(vecs[0].obj, vecs[0].w, W*H - 1);
    chk("busy_before_last", int'(busy), 1);
    // Last pixel, then a start coinciding with done must be ignored.
    beat(12'hFFF, 1'b0);
    chk("latency_done_triangle", int'(done), 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_during_done_ignored", int'(busy), 0);
    cyc();
    chk("still_idle", int'(busy), 0);
    chk("abort_done_count", done_cnt - d0, 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
